branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Pipelined, parametrised branch resolution unit for the Tomasulo back end. It accepts a dispatched branch/jump from the branch reservation station and evaluates its condition, target and link value. It compares the outcome against the front-end prediction and delivers a tagged result to the CDB/ROB side over a valid/ready handshake, with back-pressure and a global flush. It replaces the single-cycle combinational branch unit: latency is configurable, and the unit adds misprediction detection, JALR LSB masking and saturating statistics counters.

## Interface
- XLEN, 32: datapath width (pc, imm, operands, targets).
- TAG_W, 5: ROB tag width.
- LATENCY, 2: pipeline stages, legal 1..4; result latency in cycles.
- CNT_W, 16: width of each statistics counter.
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of every in-flight entry.
- in_valid  input  1  input holds a valid branch.
- in_ready  output  1  unit can accept this cycle.
- in_op  input  3  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 JAL, 7 JALR.
- in_pc, in_imm, in_rs1, in_rs2  input  XLEN  pc, sign-extended immediate, operand values.
- in_tag  input  TAG_W  ROB tag.
- in_pred_taken  input  1  front-end taken prediction.
- in_pred_target  input  XLEN  front-end predicted target.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_tag  output  TAG_W  ROB tag of result.
- out_taken  output  1  resolved direction.
- out_target  output  XLEN  correct next pc (redirect address).
- out_wb_data  output  XLEN  link value pc+4 for JAL/JALR, else 0.
- out_mispredict  output  1  redirect/flush required.
- clear_stats  input  1  synchronous clear of both counters.
- stat_branches, stat_mispredicts  output  CNT_W  saturating counters.

## Operation
- Evaluation happens combinationally on the input and is captured in stage 0.
  - taken: BEQ rs1==rs2; BNE rs1!=rs2; BLT/BGE signed compare; BLTU/BGEU unsigned compare; JAL/JALR always 1.
  - target when taken: pc+imm; JALR (rs1+imm) & ~1.
  - target when not taken: pc+4.
  - All sums are modulo 2^XLEN, with no overflow flag.
- mispredict = (taken != pred_taken) | (taken & (target != pred_target)).
  - pred_target is ignored when the branch is not taken and was predicted not taken.
- Pipeline: stages 0..LATENCY-1, each holding a valid bit plus the result fields.
  - Stage i loads from i-1 (stage 0 from input) when stage i is empty or advancing.
  - The last stage advances when out_valid & out_ready.
  - Bubbles collapse: an empty stage always accepts.
- in_ready = stage 0 empty or stage 0 advancing. It depends on out_ready combinationally through the stall chain.
- An input is accepted only when in_valid & in_ready.
- flush clears every valid bit at the edge and drops any input presented that cycle. The result data registers keep their contents. in_ready is undefined-but-harmless during flush.
- While out_valid=1 and out_ready=0, all out_* fields are held stable.
- Counters:
  - Each handshake (out_valid & out_ready) increments stat_branches.
  - A handshake that also has out_mispredict increments stat_mispredicts.
  - Both counters saturate at all-ones.
  - clear_stats has priority over increment.
  - flush does not affect the counters.

## Timing
- Reset (reset_n low, asynchronous): all valid bits 0, out_valid 0, all out_* data fields 0, counters 0. in_ready is 1 once reset is released.
- Latency: input accepted at edge E, out_valid asserted in the cycle after edge E+LATENCY-1. LATENCY=1 gives the result the cycle after acceptance.
- Throughput: one branch per cycle with out_ready held high.
- Full stall: all LATENCY stages valid and out_ready=0 gives in_ready=0. Capacity is LATENCY entries.
- Simultaneous full pipeline, out_ready=1 and in_valid=1: the shift and the accept happen in the same edge, with no bubble.
- flush on the same edge as a handshake: that output handshake completes and counts; everything else is squashed.
- reset_n asserted mid-operation: in-flight entries are lost immediately. There is no output glitch beyond out_valid falling asynchronously.

## Test plan
- Reset: assert reset_n low mid-stream with 2 entries in flight -> out_valid=0, counters 0, in_ready=1 after release.
- Direction/mispredict: BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred_taken=0 -> taken=1, target=0x120, mispredict=1. BLTU with the same operands -> taken=0, target=0x104, mispredict=0.
- JALR: rs1=0x1003, imm=0x4, pc=0x200, pred_taken=1, pred_target=0x1006 -> target=0x1006, wb_data=0x204, mispredict=0. The same branch with pred_target=0x1007 -> mispredict=1.
- Back-pressure, LATENCY=2: stream 5 branches with out_ready low for cycles 3-6 -> in_ready drops after 2 entries are held, outputs stay stable while stalled, all 5 tags emerge in order, and stat_branches=5.
- Flush: 2 entries in flight, flush plus a new in_valid in the same cycle -> no further out_valid; the next input emerges after exactly LATENCY cycles.
- Counter saturation, CNT_W=4: 20 mispredicting handshakes -> both counters read 0xF. clear_stats together with a handshake -> both counters read 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolution: evaluates direction, target and link value, flags
// mispredictions and returns tagged results over a valid/ready handshake.
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_wb_data,
  output logic             out_mispredict,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int PW = TAG_W + 2 * XLEN + 2;
  localparam logic [2:0] OP_JAL  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;
  localparam logic [XLEN-1:0] FOUR_C = XLEN'(3'd4);
  localparam logic [XLEN-1:0] ONE_C  = XLEN'(1'b1);

  logic             taken_s;
  logic             misp_s;
  logic [XLEN-1:0]  pc4_s;
  logic [XLEN-1:0]  target_s;
  logic [XLEN-1:0]  wb_s;
  logic [PW-1:0]    res_s;
  logic [LATENCY-1:0] vld_r;
  logic [LATENCY-1:0] adv_s;
  logic [LATENCY-1:0] load_s;
  logic [PW-1:0]    data_r [LATENCY];
  logic             hs_s;
  logic [CNT_W-1:0] br_cnt_r;
  logic [CNT_W-1:0] mp_cnt_r;

  // Direction, target, link value and misprediction for the presented branch
  always_comb begin
    pc4_s = in_pc + FOUR_C;
    case (in_op)
      3'd0:    taken_s = (in_rs1 == in_rs2);
      3'd1:    taken_s = (in_rs1 != in_rs2);
      3'd2:    taken_s = ($signed(in_rs1) <  $signed(in_rs2));
      3'd3:    taken_s = ($signed(in_rs1) >= $signed(in_rs2));
      3'd4:    taken_s = (in_rs1 <  in_rs2);
      3'd5:    taken_s = (in_rs1 >= in_rs2);
      default: taken_s = 1'b1;
    endcase
    if (!taken_s) begin
      target_s = pc4_s;
    end else if (in_op == OP_JALR) begin
      target_s = (in_rs1 + in_imm) & ~ONE_C;
    end else begin
      target_s = in_pc + in_imm;
    end
    if ((in_op == OP_JAL) || (in_op == OP_JALR)) begin
      wb_s = pc4_s;
    end else begin
      wb_s = {XLEN{1'b0}};
    end
    misp_s = (taken_s != in_pred_taken) | (taken_s & (target_s != in_pred_target));
    res_s  = {in_tag, taken_s, target_s, wb_s, misp_s};
  end

  // Stall chain: a stage may load when it is empty or its content moves on
  always_comb begin
    logic go_s;
    go_s   = out_ready;
    adv_s  = {LATENCY{1'b0}};
    load_s = {LATENCY{1'b0}};
    for (int i = LATENCY - 1; i >= 0; i--) begin
      adv_s[i]  = vld_r[i] & go_s;
      load_s[i] = ~vld_r[i] | go_s;
      go_s      = load_s[i];
    end
  end

  assign in_ready = load_s[0];
  assign hs_s     = vld_r[LATENCY-1] & out_ready;

  // Valid bits; flush squashes everything, including a same-cycle input
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_r <= {LATENCY{1'b0}};
    end else if (flush) begin
      vld_r <= {LATENCY{1'b0}};
    end else begin
      if (load_s[0]) vld_r[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        if (load_s[i]) vld_r[i] <= vld_r[i-1];
      end
    end
  end

  // Result payloads only move with a valid entry so stalled outputs hold still
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) data_r[i] <= {PW{1'b0}};
    end else if (!flush) begin
      if (load_s[0] && in_valid) data_r[0] <= res_s;
      for (int i = 1; i < LATENCY; i++) begin
        if (load_s[i] && vld_r[i-1]) data_r[i] <= data_r[i-1];
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      br_cnt_r <= {CNT_W{1'b0}};
      mp_cnt_r <= {CNT_W{1'b0}};
    end else if (clear_stats) begin
      br_cnt_r <= {CNT_W{1'b0}};
      mp_cnt_r <= {CNT_W{1'b0}};
    end else if (hs_s) begin
      if (br_cnt_r != {CNT_W{1'b1}}) br_cnt_r <= br_cnt_r + CNT_W'(1'b1);
      if (out_mispredict && (mp_cnt_r != {CNT_W{1'b1}})) mp_cnt_r <= mp_cnt_r + CNT_W'(1'b1);
    end
  end

  assign out_valid = vld_r[LATENCY-1];
  assign {out_tag, out_taken, out_target, out_wb_data, out_mispredict} = data_r[LATENCY-1];
  assign stat_branches    = br_cnt_r;
  assign stat_mispredicts = mp_cnt_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: random and directed branches checked
// against a behavioural model of the resolution rules.
module tb_branch_resolve_unit;
  localparam int XLEN = 32, TAG_W = 5, LAT = 2, CNT_W = 4;

  typedef struct {
    bit [4:0]  tag;
    bit        taken;
    bit [31:0] target;
    bit [31:0] wb;
    bit        misp;
  } exp_t;

  logic clock = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
  logic [2:0] in_op = 3'd0;
  logic [31:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_rs2 = '0, in_pred_target = '0;
  logic [4:0] in_tag = '0;
  logic in_pred_taken = 1'b0, out_valid, out_ready = 1'b0, out_taken, out_mispredict;
  logic [4:0] out_tag;
  logic [31:0] out_target, out_wb_data;
  logic clear_stats = 1'b0;
  logic [3:0] stat_branches, stat_mispredicts;

  int n_chk = 0, n_fail = 0;
  exp_t q[$];
  bit dir_en = 0;
  exp_t dir_exp;
  bit [3:0] m_br = 0, m_mp = 0;
  bit held = 0;
  exp_t held_v;

  branch_resolve_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_tag(in_tag), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_taken(out_taken),
    .out_target(out_target), .out_wb_data(out_wb_data), .out_mispredict(out_mispredict),
    .clear_stats(clear_stats), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: resolution rules written as plain arithmetic on the ISA semantics
  function automatic exp_t model(bit [2:0] op, bit [31:0] pc, imm, rs1, rs2,
                                 bit [4:0] tag, bit pt, bit [31:0] ptg);
    exp_t e;
    longint s1 = longint'($signed(rs1)), s2 = longint'($signed(rs2));
    longint u1 = longint'(rs1), u2 = longint'(rs2);
    bit t;
    case (op)
      0: t = (u1 == u2);
      1: t = (u1 != u2);
      2: t = (s1 < s2);
      3: t = (s1 >= s2);
      4: t = (u1 < u2);
      5: t = (u1 >= u2);
      default: t = 1;
    endcase
    e.tag = tag;
    e.taken = t;
    if (!t) e.target = 32'((longint'(pc) + 4) % 64'h1_0000_0000);
    else if (op == 7) e.target = 32'(((longint'(rs1) + longint'(imm)) % 64'h1_0000_0000) / 2 * 2);
    else e.target = 32'((longint'(pc) + longint'(imm)) % 64'h1_0000_0000);
    e.wb = (op >= 6) ? 32'((longint'(pc) + 4) % 64'h1_0000_0000) : 32'd0;
    e.misp = (t != pt) || (t && (e.target != ptg));
    return e;
  endfunction

  // Expected-response producer: records each accepted branch
  always @(negedge clock) begin
    if (reset_n && !flush && in_valid && in_ready) begin
      if (dir_en) q.push_back(dir_exp);
      else q.push_back(model(in_op, in_pc, in_imm, in_rs1, in_rs2, in_tag, in_pred_taken, in_pred_target));
    end
  end

  // Monitor: compares outputs, stability under stall and statistics
  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      m_br = 0; m_mp = 0; held = 0;
    end else begin
      chk("stat_branches", stat_branches, m_br);
      chk("stat_mispredicts", stat_mispredicts, m_mp);
      if (held) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_tag", out_tag, held_v.tag);
        chk("stall_target", out_target, held_v.target);
      end
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_out", 0, 1);
        else begin
          chk("tag", out_tag, q[0].tag);
          chk("taken", out_taken, q[0].taken);
          chk("target", out_target, q[0].target);
          chk("wb_data", out_wb_data, q[0].wb);
          chk("mispredict", out_mispredict, q[0].misp);
          held_v = q[0];
        end
        held = !out_ready;
        if (out_ready && q.size() != 0) void'(q.pop_front());
      end else held = 0;
      if (clear_stats) begin m_br = 0; m_mp = 0; end
      else if (out_valid && out_ready) begin
        if (m_br != 4'hF) m_br++;
        if (out_mispredict && m_mp != 4'hF) m_mp++;
      end
      if (flush) begin q.delete(); held = 0; end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input bit [2:0] op, input bit [31:0] pc, imm, rs1, rs2,
                      input bit [4:0] tag, input bit pt, input bit [31:0] ptg);
    bit done = 0;
    in_op = op; in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
    in_tag = tag; in_pred_taken = pt; in_pred_target = ptg; in_valid = 1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clock); done = in_ready;
      @(posedge clock); #1;
    end
    chk("send_accept", done, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    bit empty = 0;
    out_ready = 1; in_valid = 0;
    for (int k = 0; k < 50 && !empty; k++) begin
      cyc(1);
      empty = (q.size() == 0) && !out_valid;
    end
    chk("drain_done", empty, 1);
  endtask

  task automatic clr();
    clear_stats = 1; cyc(1); clear_stats = 0;
  endtask

  task automatic directed(input bit [2:0] op, input bit [31:0] pc, imm, rs1, rs2, input bit [4:0] tag,
                          input bit pt, input bit [31:0] ptg, input bit et, input bit [31:0] etg,
                          input bit [31:0] ewb, input bit emp);
    dir_exp = '{tag: tag, taken: et, target: etg, wb: ewb, misp: emp};
    dir_en = 1;
    send(op, pc, imm, rs1, rs2, tag, pt, ptg);
    dir_en = 0;
  endtask

  initial begin
    bit [31:0] r1, r2;
    bit saw_block;
    int sent, lat;
    exp_t e;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_target", out_target, 0);
    reset_n = 1;
    cyc(1);
    chk("rst_in_ready", in_ready, 1);

    // Directed resolution cases
    out_ready = 1;
    directed(3'd2, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 5'd1, 0, 32'h0, 1, 32'h120, 32'h0, 1);
    directed(3'd4, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 5'd2, 0, 32'h0, 0, 32'h104, 32'h0, 0);
    directed(3'd7, 32'h200, 32'h4, 32'h1003, 32'h0, 5'd3, 1, 32'h1006, 1, 32'h1006, 32'h204, 0);
    directed(3'd7, 32'h200, 32'h4, 32'h1003, 32'h0, 5'd4, 1, 32'h1007, 1, 32'h1006, 32'h204, 1);
    drain();

    // Back-pressure: five branches, consumer stalled for cycles 3..6
    clr();
    sent = 0; saw_block = 0;
    for (int c = 0; c < 40 && (sent < 5 || q.size() != 0 || out_valid); c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid = (sent < 5);
      in_op = 3'($urandom_range(0, 7)); in_pc = $urandom; in_imm = $urandom;
      in_rs1 = $urandom; in_rs2 = $urandom; in_tag = 5'(10 + sent);
      in_pred_taken = 1'($urandom); in_pred_target = $urandom;
      @(negedge clock);
      if (in_valid && in_ready) sent++;
      if (in_valid && !in_ready) saw_block = 1;
      @(posedge clock); #1;
    end
    in_valid = 0;
    chk("bp_in_ready_dropped", saw_block, 1);
    chk("bp_sent", sent, 5);
    chk("bp_stat_branches", stat_branches, 5);

    // Flush with two entries held and a new input in the same cycle
    out_ready = 0;
    send(3'd6, 32'h300, 32'h40, 0, 0, 5'd20, 1, 32'h340);
    send(3'd6, 32'h310, 32'h40, 0, 0, 5'd21, 1, 32'h350);
    in_op = 3'd6; in_tag = 5'd22; in_valid = 1; flush = 1;
    cyc(1);
    flush = 0; in_valid = 0; out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); chk("flush_no_out", out_valid, 0);
    end
    @(posedge clock); #1;
    in_op = 3'd0; in_rs1 = 5; in_rs2 = 5; in_pc = 32'h400; in_imm = 32'h8; in_tag = 5'd23;
    in_pred_taken = 1; in_pred_target = 32'h408; in_valid = 1;
    @(negedge clock); chk("lat_in_ready", in_ready, 1);
    @(posedge clock); #1; in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 10) begin cyc(1); lat++; end
    chk("latency", lat, LAT);
    drain();

    // Saturation, then clear coinciding with a handshake
    clr();
    for (int k = 0; k < 20; k++) send(3'd6, 32'h500 + 32'(k), 32'h10, 0, 0, 5'(k), 0, 32'h0);
    drain();
    chk("sat_branches", stat_branches, 4'hF);
    chk("sat_mispredicts", stat_mispredicts, 4'hF);
    out_ready = 0;
    send(3'd6, 32'h600, 32'h10, 0, 0, 5'd9, 0, 32'h0);
    for (int k = 0; k < 10 && !out_valid; k++) cyc(1);
    clear_stats = 1; out_ready = 1;
    cyc(1);
    clear_stats = 0;
    chk("clr_hs_branches", stat_branches, 0);
    chk("clr_hs_mispredicts", stat_mispredicts, 0);
    drain();

    // Reset with two entries in flight
    out_ready = 0;
    send(3'd1, 32'h700, 32'h4, 1, 2, 5'd5, 1, 32'h704);
    send(3'd1, 32'h710, 32'h4, 1, 2, 5'd6, 1, 32'h714);
    #3 reset_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_stat_br", stat_branches, 0);
    chk("arst_stat_mp", stat_mispredicts, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_out_wb", out_wb_data, 0);
    @(negedge clock); #2 reset_n = 1;
    @(posedge clock); #1;
    chk("arst_in_ready", in_ready, 1);

    // Random traffic with back-pressure, flushes and clears
    for (int c = 0; c < 400; c++) begin
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      in_op = 3'($urandom_range(0, 7)); in_pc = $urandom; in_imm = $urandom;
      in_rs1 = r1; in_rs2 = r2; in_tag = 5'($urandom); in_pred_taken = 1'($urandom);
      e = model(in_op, in_pc, in_imm, in_rs1, in_rs2, in_tag, in_pred_taken, 32'h0);
      in_pred_target = ($urandom_range(0, 1) == 0) ? e.target : $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 39) == 0);
      clear_stats = ($urandom_range(0, 39) == 0);
      cyc(1);
    end
    flush = 0; clear_stats = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
